// File: rtl/i2s_tx_serializer_pkg.sv
// Shared definitions for the I2S transmit serializer: word-select encoding and
// the slot-width legality rule.
package i2s_pkg;

    typedef enum logic {
        WS_LEFT  = 1'b0,
        WS_RIGHT = 1'b1
    } ws_e;

    // A slot needs the one-bit I2S delay period plus room for every data bit.
    function automatic int unsigned min_slot_w(input int unsigned data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Sample-pair valid/ready handshake between the audio source and the serializer.
interface i2s_tx_serializer_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_left;
    logic [DATA_W-1:0] in_right;
    logic              in_ready;

    modport master (output in_valid, output in_left, output in_right, input  in_ready);
    modport slave  (input  in_valid, input  in_left, input  in_right, output in_ready);
endinterface

// File: rtl/i2s_tx_serializer_bit_order.sv
// Combinational word reverser; passes the word through unchanged when REVERSE=0.
module i2s_bit_order #(
    parameter int unsigned DATA_W  = 16,
    parameter bit          REVERSE = 1'b0
) (
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (REVERSE) begin
            for (int unsigned i = 0; i < DATA_W; i++) begin
                dout[i] = din[DATA_W-1-i];
            end
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: buffers one stereo pair and shifts it out with the
// standard one-bit delay after each word-select change.
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SLOT_W    = 32,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sclk_en,
    i2s_tx_serializer_if.slave  in_if,
    output logic                ws,
    output logic                sd,
    output logic                frame_start,
    output logic                underrun
);

    localparam int unsigned     CNT_W    = $clog2(SLOT_W);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] DATA_END = CNT_W'(DATA_W);

    if (DATA_W < 1) begin : g_bad_data_w
        $error("i2s_tx_serializer: DATA_W must be at least 1");
    end
    if (SLOT_W < min_slot_w(DATA_W)) begin : g_bad_slot_w
        $error("i2s_tx_serializer: SLOT_W must be at least DATA_W+1");
    end

    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    ws_e               ch_q, ch_d;
    logic [DATA_W-1:0] pend_l_q, pend_l_d;
    logic [DATA_W-1:0] pend_r_q, pend_r_d;
    logic              pend_full_q, pend_full_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] r_hold_q, r_hold_d;
    logic              sd_q, sd_d;
    logic              frame_start_q, frame_start_d;
    logic              underrun_q, underrun_d;

    logic [DATA_W-1:0] pend_l_ord, pend_r_ord;
    logic              accept;

    i2s_bit_order #(.DATA_W(DATA_W), .REVERSE(!MSB_FIRST)) u_order_l (
        .din  (pend_l_q),
        .dout (pend_l_ord)
    );

    i2s_bit_order #(.DATA_W(DATA_W), .REVERSE(!MSB_FIRST)) u_order_r (
        .din  (pend_r_q),
        .dout (pend_r_ord)
    );

    assign accept = in_if.in_valid && !pend_full_q;

    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        ch_d          = ch_q;
        pend_l_d      = pend_l_q;
        pend_r_d      = pend_r_q;
        pend_full_d   = pend_full_q;
        shreg_d       = shreg_q;
        r_hold_d      = r_hold_q;
        sd_d          = sd_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (accept) begin
            pend_l_d    = in_if.in_left;
            pend_r_d    = in_if.in_right;
            pend_full_d = 1'b1;
        end

        if (sclk_en) begin
            if (bit_cnt_q == LAST) begin
                bit_cnt_d = '0;
                ch_d      = (ch_q == WS_LEFT) ? WS_RIGHT : WS_LEFT;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end

            sd_d = 1'b0;
            if (bit_cnt_d == '0) begin
                if (ch_d == WS_LEFT) begin
                    frame_start_d = 1'b1;
                    // A full buffer means in_ready was low, so this never races an accept.
                    if (pend_full_q) begin
                        shreg_d     = pend_l_ord;
                        r_hold_d    = pend_r_ord;
                        pend_full_d = 1'b0;
                    end else begin
                        shreg_d    = '0;
                        r_hold_d   = '0;
                        underrun_d = 1'b1;
                    end
                end else begin
                    shreg_d = r_hold_q;
                end
            end else if (bit_cnt_d <= DATA_END) begin
                sd_d    = shreg_q[DATA_W-1];
                shreg_d = shreg_q << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q     <= LAST;
            ch_q          <= WS_RIGHT;
            pend_l_q      <= '0;
            pend_r_q      <= '0;
            pend_full_q   <= 1'b0;
            shreg_q       <= '0;
            r_hold_q      <= '0;
            sd_q          <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            ch_q          <= ch_d;
            pend_l_q      <= pend_l_d;
            pend_r_q      <= pend_r_d;
            pend_full_q   <= pend_full_d;
            shreg_q       <= shreg_d;
            r_hold_q      <= r_hold_d;
            sd_q          <= sd_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign in_if.in_ready = !pend_full_q;
    assign ws             = ch_q;
    assign sd             = sd_q;
    assign frame_start    = frame_start_q;
    assign underrun       = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: an MSB-first and an LSB-first instance share stimulus;
// a cycle model feeds a scoreboard and hand-written slot patterns are checked per frame.
module tb_i2s_tx_serializer;

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 32;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        sclk_en = 1'b0;
    int unsigned tick_div = 4;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    i2s_tx_serializer_if #(.DATA_W(DW)) if_m ();
    i2s_tx_serializer_if #(.DATA_W(DW)) if_l ();

    logic ws_m, sd_m, fs_m, ur_m;
    logic ws_l, sd_l, fs_l, ur_l;

    i2s_tx_serializer #(.DATA_W(DW), .SLOT_W(SW), .MSB_FIRST(1'b1)) u_dut_m (
        .clk(clk), .rst_n(rst_n), .sclk_en(sclk_en), .in_if(if_m.slave),
        .ws(ws_m), .sd(sd_m), .frame_start(fs_m), .underrun(ur_m)
    );

    i2s_tx_serializer #(.DATA_W(DW), .SLOT_W(SW), .MSB_FIRST(1'b0)) u_dut_l (
        .clk(clk), .rst_n(rst_n), .sclk_en(sclk_en), .in_if(if_l.slave),
        .ws(ws_l), .sd(sd_l), .frame_start(fs_l), .underrun(ur_l)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    task automatic set_in(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
        if_m.in_valid = v; if_m.in_left = l; if_m.in_right = r;
        if_l.in_valid = v; if_l.in_left = l; if_l.in_right = r;
    endtask

    // Bit-clock strobe generator
    initial begin
        int unsigned c = 0;
        forever begin
            @(negedge clk);
            if (c + 1 >= tick_div) begin sclk_en = 1'b1; c = 0; end
            else begin sclk_en = 1'b0; c++; end
        end
    end

    // Cycle model and scoreboard
    typedef struct {
        logic sd_m, sd_l, ws, fs, ur, rdy;
    } exp_t;
    exp_t sb[$];

    int          m_cnt;
    logic        m_ch, m_full;
    logic [DW-1:0] m_pl, m_pr, m_cl, m_cr;
    logic        x_sd_m, x_sd_l, x_fs, x_ur;
    int unsigned tick_cnt, last_fs_tick;
    bit          fs_seen;
    int unsigned fs_cnt, ur_cnt;

    always @(posedge clk) begin
        exp_t e;
        bit acc;
        logic [DW-1:0] w;
        if (!rst_n) begin
            m_cnt = SW - 1; m_ch = 1'b1; m_full = 1'b0;
            m_cl = '0; m_cr = '0;
            x_sd_m = 1'b0; x_sd_l = 1'b0; x_fs = 1'b0; x_ur = 1'b0;
            fs_seen = 1'b0; tick_cnt = 0;
        end else begin
            acc  = if_m.in_valid && !m_full;
            x_fs = 1'b0;
            x_ur = 1'b0;
            if (sclk_en) begin
                tick_cnt++;
                if (m_cnt == SW - 1) begin m_cnt = 0; m_ch = !m_ch; end
                else m_cnt++;
                if (m_cnt == 0 && m_ch == 1'b0) begin
                    x_fs = 1'b1;
                    if (m_full) begin m_cl = m_pl; m_cr = m_pr; m_full = 1'b0; end
                    else begin m_cl = '0; m_cr = '0; x_ur = 1'b1; end
                end
                w = m_ch ? m_cr : m_cl;
                if (m_cnt >= 1 && m_cnt <= DW) begin
                    x_sd_m = w[DW - m_cnt];
                    x_sd_l = w[m_cnt - 1];
                end else begin
                    x_sd_m = 1'b0;
                    x_sd_l = 1'b0;
                end
            end
            if (acc) begin m_pl = if_m.in_left; m_pr = if_m.in_right; m_full = 1'b1; end
        end
        e.sd_m = x_sd_m; e.sd_l = x_sd_l; e.ws = m_ch;
        e.fs = x_fs; e.ur = x_ur; e.rdy = !m_full;
        sb.push_back(e);

        #1;
        e = sb.pop_front();
        chk("cyc_sd_msb",  sd_m, e.sd_m);
        chk("cyc_sd_lsb",  sd_l, e.sd_l);
        chk("cyc_ws_msb",  ws_m, e.ws);
        chk("cyc_ws_lsb",  ws_l, e.ws);
        chk("cyc_fs_msb",  fs_m, e.fs);
        chk("cyc_fs_lsb",  fs_l, e.fs);
        chk("cyc_ur_msb",  ur_m, e.ur);
        chk("cyc_ur_lsb",  ur_l, e.ur);
        chk("cyc_rdy_msb", if_m.in_ready, e.rdy);
        chk("cyc_rdy_lsb", if_l.in_ready, e.rdy);
        if (fs_m === 1'b1) begin
            fs_cnt++;
            if (fs_seen) chk("fs_spacing_ticks", tick_cnt - last_fs_tick, 64);
            fs_seen = 1'b1;
            last_fs_tick = tick_cnt;
        end
        if (ur_m === 1'b1) ur_cnt++;
    end

    task automatic wait_tick();
        int unsigned g = 0;
        do begin @(posedge clk); g++; end while (!sclk_en && g < 100);
        if (!sclk_en) fail_now("tick_wait");
    endtask

    task automatic wait_fs();
        int unsigned g = 0;
        do begin @(negedge clk); g++; end while (fs_m !== 1'b1 && g < 2000);
        if (fs_m !== 1'b1) fail_now("frame_start_wait");
    endtask

    // Captures one frame (64 bit periods), period 0 of the left slot in bit 63.
    task automatic capture(input bit at_fs, output logic [63:0] sdm, output logic [63:0] sdl,
                           output logic [63:0] wsm);
        if (!at_fs) wait_fs();
        sdm[63] = sd_m; sdl[63] = sd_l; wsm[63] = ws_m;
        for (int i = 1; i < 64; i++) begin
            wait_tick();
            @(negedge clk);
            sdm[63-i] = sd_m; sdl[63-i] = sd_l; wsm[63-i] = ws_m;
        end
    endtask

    typedef struct {
        logic [DW-1:0] l, r;
        logic [31:0]   xl_m, xr_m, xl_l;
    } vec_t;

    initial begin
        vec_t vecs[4];
        logic [63:0] sdm, sdl, wsm;
        int unsigned g;

        vecs[0] = '{l: 16'hA5C3, r: 16'h0001, xl_m: {1'b0, 16'hA5C3, 15'h0},
                    xr_m: {1'b0, 16'h0001, 15'h0}, xl_l: {1'b0, 16'hC3A5, 15'h0}};
        vecs[1] = '{l: 16'h0001, r: 16'h8000, xl_m: {1'b0, 16'h0001, 15'h0},
                    xr_m: {1'b0, 16'h8000, 15'h0}, xl_l: {1'b0, 16'h8000, 15'h0}};
        vecs[2] = '{l: 16'hFFFF, r: 16'h1234, xl_m: {1'b0, 16'hFFFF, 15'h0},
                    xr_m: {1'b0, 16'h1234, 15'h0}, xl_l: {1'b0, 16'hFFFF, 15'h0}};
        vecs[3] = '{l: 16'h1234, r: 16'hFFFF, xl_m: {1'b0, 16'h1234, 15'h0},
                    xr_m: {1'b0, 16'hFFFF, 15'h0}, xl_l: {1'b0, 16'h2C48, 15'h0}};

        set_in(1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst_sd",  {sd_m, sd_l}, 2'b00);
        chk("rst_ws",  {ws_m, ws_l}, 2'b11);
        chk("rst_rdy", {if_m.in_ready, if_l.in_ready}, 2'b11);
        chk("rst_fs",  {fs_m, fs_l}, 2'b00);
        chk("rst_ur",  {ur_m, ur_l}, 2'b00);
        rst_n = 1'b1;

        // Idle frames: silence, underrun each frame, 32 left then 32 right
        fs_cnt = 0; ur_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            capture(1'b0, sdm, sdl, wsm);
            chk("idle_sd_msb", sdm, 64'h0);
            chk("idle_sd_lsb", sdl, 64'h0);
            chk("idle_ws", wsm, {32'h0, 32'hFFFF_FFFF});
        end
        chk("idle_fs_count", fs_cnt, 2);
        chk("idle_ur_count", ur_cnt, 2);

        // Table: accept at a frame start, transmit in the next frame
        for (int v = 0; v < 4; v++) begin
            wait_fs();
            chk("vec_rdy_before", if_m.in_ready, 1'b1);
            set_in(1'b1, vecs[v].l, vecs[v].r);
            @(negedge clk);
            set_in(1'b0, '0, '0);
            ur_cnt = 0;
            capture(1'b0, sdm, sdl, wsm);
            chk("vec_left_msb",  sdm[63:32], vecs[v].xl_m);
            chk("vec_right_msb", sdm[31:0],  vecs[v].xr_m);
            chk("vec_left_lsb",  sdl[63:32], vecs[v].xl_l);
            chk("vec_ws", wsm, {32'h0, 32'hFFFF_FFFF});
            chk("vec_no_underrun", ur_cnt, 0);
        end

        // Back-pressure: B waits until the A frame-start load frees the buffer
        wait_fs();
        set_in(1'b1, vecs[0].l, vecs[0].r);
        @(negedge clk);
        set_in(1'b1, vecs[2].l, vecs[2].r);
        chk("bp_rdy_low", if_m.in_ready, 1'b0);
        g = 0;
        while (if_m.in_ready !== 1'b1 && g < 2000) begin
            @(negedge clk);
            g++;
            if (if_m.in_ready !== 1'b1 && fs_m === 1'b1) chk("bp_rdy_at_load", if_m.in_ready, 1'b1);
        end
        if (if_m.in_ready !== 1'b1) fail_now("bp_ready_wait");
        chk("bp_rdy_with_fs", fs_m, 1'b1);
        fork
            begin @(negedge clk); set_in(1'b0, '0, '0); end
        join_none
        capture(1'b1, sdm, sdl, wsm);
        chk("bp_frame_a", sdm, {vecs[0].xl_m, vecs[0].xr_m});
        capture(1'b0, sdm, sdl, wsm);
        chk("bp_frame_b", sdm, {vecs[2].xl_m, vecs[2].xr_m});
        chk("bp_frame_b_lsb", sdl[63:32], vecs[2].xl_l);

        // Accept in the same cycle as a left-slot tick with an empty buffer
        g = 0;
        do begin @(negedge clk); #1; g++; end
        while (!(sclk_en && m_cnt == SW - 1 && m_ch == 1'b1) && g < 2000);
        if (g >= 2000) fail_now("simul_tick_wait");
        set_in(1'b1, vecs[3].l, vecs[3].r);
        @(negedge clk);
        set_in(1'b0, '0, '0);
        chk("simul_underrun", {ur_m, ur_l}, 2'b11);
        chk("simul_fs", fs_m, 1'b1);
        capture(1'b1, sdm, sdl, wsm);
        chk("simul_zero_frame", sdm, 64'h0);
        capture(1'b0, sdm, sdl, wsm);
        chk("simul_next_frame", sdm, {vecs[3].xl_m, vecs[3].xr_m});
        chk("simul_next_lsb", sdl[63:32], vecs[3].xl_l);

        // Reset in the right slot at bit_cnt=10 with a pair pending
        g = 0;
        do begin @(negedge clk); #1; g++; end while (!(m_ch == 1'b1 && m_cnt == 5) && g < 2000);
        set_in(1'b1, vecs[1].l, vecs[1].r);
        @(negedge clk);
        set_in(1'b0, '0, '0);
        g = 0;
        do begin @(negedge clk); #1; g++; end while (!(m_ch == 1'b1 && m_cnt == 10) && g < 2000);
        if (g >= 2000) fail_now("reset_point_wait");
        chk("pre_rst_rdy", if_m.in_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_sd",  {sd_m, sd_l}, 2'b00);
        chk("midrst_ws",  {ws_m, ws_l}, 2'b11);
        chk("midrst_rdy", {if_m.in_ready, if_l.in_ready}, 2'b11);
        chk("midrst_fs",  {fs_m, fs_l}, 2'b00);
        chk("midrst_ur",  {ur_m, ur_l}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_tick();
        @(negedge clk);
        chk("post_rst_fs", fs_m, 1'b1);
        chk("post_rst_ur", ur_m, 1'b1);
        chk("post_rst_ws", ws_m, 1'b0);

        // Back-to-back bit clock
        tick_div = 1;
        wait_fs();
        set_in(1'b1, vecs[0].l, vecs[0].r);
        @(negedge clk);
        set_in(1'b0, '0, '0);
        capture(1'b0, sdm, sdl, wsm);
        chk("b2b_frame_msb", sdm, {vecs[0].xl_m, vecs[0].xr_m});
        chk("b2b_left_lsb", sdl[63:32], vecs[0].xl_l);
        chk("b2b_ws", wsm, {32'h0, 32'hFFFF_FFFF});

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Parametrised I2S transmit serializer: accepts one stereo sample pair (left, right) per frame over a valid/ready handshake and shifts it out on the serial data line, with the word-select signal generated internally. The block sits between the audio sample source and the pad drivers for WS and SD. It runs from a single system clock, with a bit-clock tick strobe. Bit order is selectable at elaboration, so the same block serves both MSB-first and LSB-first links.

## Interface
- DATA_W, 16, sample width in bits; minimum 1.
- SLOT_W, 32, bit periods per channel slot; must satisfy SLOT_W ≥ DATA_W+1.
- MSB_FIRST, 1, sets the bit order on the line:
  - 1: MSB first.
  - 0: LSB first. The word is bit-reversed at load.
- clk, input, 1, system clock. All logic is on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- sclk_en, input, 1, one-cycle strobe that marks the start of each bit period (the bit-clock edge on which SD/WS change).
- in_valid, input, 1, sample pair valid.
- in_left, input, DATA_W, left sample.
- in_right, input, DATA_W, right sample.
- in_ready, output, 1, pending buffer can accept a pair.
- ws, output, 1, word select (0 = left, 1 = right).
- sd, output, 1, serial data.
- frame_start, output, 1, one-cycle pulse on the tick that starts a left slot.
- underrun, output, 1, one-cycle pulse when a frame starts with no pending pair.

## Operation
- **State**
  - bit_cnt: 0..SLOT_W-1.
  - ch: 0 = left, 1 = right.
  - Pending buffer: pend_l, pend_r, pend_full.
  - Shift register shreg, DATA_W wide.
  - Right hold register r_hold.
- **Handshake**
  - in_ready = !pend_full.
  - A pair is accepted when in_valid && in_ready: it is written to the pending buffer and pend_full is set.
  - Sample inputs are ignored otherwise.
- **Tick behaviour.** Nothing advances without sclk_en. On each sclk_en:
  - If bit_cnt == SLOT_W-1: wrap bit_cnt to 0 and toggle ch.
  - Otherwise: increment bit_cnt.
- **Left slot start** (tick entering bit_cnt=0 with ch=0):
  - If pend_full: load shreg ← pend_l and r_hold ← pend_r, then clear pend_full.
  - Otherwise: load zeros into both registers and pulse underrun.
  - frame_start pulses.
- **Right slot start:** shreg ← r_hold.
- **Slot layout (I2S one-bit delay)**
  - ws = ch.
  - Bit period 0: sd = 0.
  - Bit periods 1..DATA_W: sd = the current shreg MSB, then shreg shifts left.
  - Bit periods DATA_W+1..SLOT_W-1: sd = 0.
- **Bit order.** When MSB_FIRST=0, the loaded word is bit-reversed: line bit k = sample bit k.
- **Simultaneous accept and left-slot load**
  - If pend_full=1: the load consumes the old pair. in_ready was low, so there is no accept that cycle.
  - If pend_full=0: the frame underruns. The pair accepted in the same cycle goes to the pending buffer and is used in the next frame.
- **Tick and accept are independent.** The pending buffer write and the tick logic may occur in the same clk cycle.

## Timing
- **Reset values**
  - sd=0, ws=1, in_ready=1, frame_start=0, underrun=0.
  - bit_cnt=SLOT_W-1, ch=1 (right), pend_full=0, shreg=0, r_hold=0.
  - The first sclk_en after reset therefore enters left slot period 0, and that frame underruns unless a pair was accepted earlier.
- **Output registration**
  - All outputs are registered.
  - sd, ws, frame_start and underrun update in the clk cycle in which sclk_en=1, and are visible from the next cycle.
  - frame_start and underrun last exactly one clk cycle.
- **in_ready latency:** in_ready rises in the cycle after the left-slot load that cleared pend_full.
- **Latency:** a pair accepted before a left-slot tick has its first data bit on sd at the following tick (bit period 1).
- **Back-to-back sclk_en** (every cycle) must work. It gives a 1 clk bit period.
- **Reset mid-frame:** asynchronous return to the reset values. The pending pair is discarded.

## Structure
- Package i2s_pkg holds:
  - The WS encoding constants (WS_LEFT=0, WS_RIGHT=1).
  - A function or constant for the minimum SLOT_W check.
- Elaboration-time assertion: SLOT_W ≥ DATA_W+1.
- Sub-module i2s_bit_order: a parametrised combinational DATA_W reverser with a REVERSE parameter. It is instantiated on the load path, with REVERSE = !MSB_FIRST.

## Test plan
- **Reset then idle ticks:** DATA_W=16, SLOT_W=32, sclk_en every 4 clks, no input.
  - ws sequence is 32×0 then 32×1.
  - sd is constantly 0.
  - underrun pulses once per frame.
  - frame_start pulses every 64 ticks.
- **MSB-first load:** accept L=0xA5C3, R=0x0001 before a frame.
  - Left slot sd = 0, then 1010010111000011, then 15×0.
  - Right slot sd = 0, then 0000000000000001, then 15×0.
  - No underrun.
- **LSB-first (MSB_FIRST=0), L=0x0001:** left slot sd = 0, 1, then 30×0.
- **Back-pressure:**
  - Accept pair A. in_ready goes low.
  - Hold in_valid with pair B: B is not accepted until the cycle after the A frame-start load. in_ready stays low until then.
  - The next frame transmits B.
- **Simultaneous accept and frame start with empty buffer:** in_valid asserted in the same cycle as the left-slot tick.
  - underrun=1 and that frame's data is zero.
  - The accepted pair is sent in the next frame.
- **Reset asserted mid right slot (bit_cnt=10):** outputs go to their reset values immediately. After release, the first tick starts a left slot.
